// File: rtl/gf2_pkg.sv
// Shared GF(2) helpers for the solver and the RREF engine: the solver state
// type, a clog2 that never returns less than 1, and a popcount.
package gf2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_ENUM = 2'd2,
    ST_DONE = 2'd3
  } solver_state_e;

  function automatic int clog2_f1(input int n);
    int r;
    r = $clog2(n);
    return (r < 1) ? 1 : r;
  endfunction

  // Operands narrower than 64 bits are zero-extended by the caller.
  function automatic int unsigned popcount(input logic [63:0] v);
    int unsigned c;
    c = 0;
    for (int i = 0; i < 64; i++) begin
      c += 32'(v[i]);
    end
    return c;
  endfunction

endpackage

// File: rtl/gf2_min_weight_solver_if.sv
// Request/result bundle for gf2_min_weight_solver. With
// GF2_MIN_WEIGHT_SOLVER_SOLUTION_OUT_EN defined it also carries the argmin vector.
interface gf2_min_weight_solver_if
  import gf2_pkg::*;
#(
  parameter int MAX_ROWS = 16,
  parameter int MAX_COLS = 16
);
  localparam int MAX_ROWS_W = clog2_f1(MAX_ROWS + 1);
  localparam int MAX_COLS_W = clog2_f1(MAX_COLS + 1);

  logic                               start;
  logic [MAX_ROWS_W-1:0]              rows;
  logic [MAX_COLS_W-1:0]              cols;
  logic [MAX_ROWS-1:0][MAX_COLS-1:0]  RREF;
  logic                               ready;
  logic                               solvable;
  logic                               overflow;
  logic [MAX_COLS_W-1:0]              min_weight;
  logic                               busy;
`ifdef GF2_MIN_WEIGHT_SOLVER_SOLUTION_OUT_EN
  logic [MAX_COLS-1:0]                solution;
`endif

  modport master (
    output start, rows, cols, RREF,
`ifdef GF2_MIN_WEIGHT_SOLVER_SOLUTION_OUT_EN
    input  solution,
`endif
    input  ready, solvable, overflow, min_weight, busy
  );

  modport slave (
    input  start, rows, cols, RREF,
`ifdef GF2_MIN_WEIGHT_SOLVER_SOLUTION_OUT_EN
    output solution,
`endif
    output ready, solvable, overflow, min_weight, busy
  );

endinterface

// File: rtl/gf2_min_weight_solver_pdep.sv
// gf2_pdep: deposits the low counter bits into the set positions of mask,
// counter bit 0 going to the most significant set position (lowest variable).
module gf2_pdep #(
  parameter int MAX_COLS = 16,
  parameter int MAX_FREE = 8
) (
  input  logic [MAX_FREE-1:0] cnt,
  input  logic [MAX_COLS-1:0] mask,
  output logic [MAX_COLS-1:0] dep
);

  always_comb begin
    int k;
    dep = '0;
    k   = 0;
    for (int b = MAX_COLS - 1; b >= 0; b--) begin
      if (mask[b]) begin
        if (k < MAX_FREE) begin
          dep[b] = cnt[k];
        end
        k++;
      end
    end
  end

endmodule

// File: rtl/gf2_min_weight_solver.sv
// Minimum Hamming-weight solver for an RREF system [A|b] over GF(2).
// Optional argmin output enabled by GF2_MIN_WEIGHT_SOLVER_SOLUTION_OUT_EN.
module gf2_min_weight_solver
  import gf2_pkg::*;
#(
  parameter int MAX_ROWS = 16,
  parameter int MAX_COLS = 16,
  parameter int MAX_FREE = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  gf2_min_weight_solver_if.slave bus
);
  localparam int MAX_ROWS_W     = clog2_f1(MAX_ROWS + 1);
  localparam int MAX_COLS_W     = clog2_f1(MAX_COLS + 1);
  localparam int MAX_COLS_IDX_W = clog2_f1(MAX_COLS);
  localparam int ROW_IDX_W      = clog2_f1(MAX_ROWS);

  solver_state_e state_reg, state_next;

  logic [MAX_ROWS-1:0][MAX_COLS-1:0]       mat_reg;
  logic [MAX_ROWS_W-1:0]                   rows_reg;
  logic [MAX_COLS_W-1:0]                   cols_reg;
  logic [MAX_ROWS_W-1:0]                   row_idx_reg;
  logic [MAX_COLS-1:0]                     pivot_mask_reg;
  logic [MAX_ROWS-1:0][MAX_COLS_IDX_W-1:0] pivot_col_reg;
  logic [MAX_ROWS-1:0]                     pivot_valid_reg;
  logic                                    incons_reg;
  logic                                    free_ovf_reg;
  logic [MAX_COLS-1:0]                     free_mask_reg;
  logic [MAX_COLS_W-1:0]                   nfree_reg;
  logic [MAX_FREE-1:0]                     cnt_reg;
  logic [MAX_COLS_W-1:0]                   best_w_reg;
  logic                                    ready_reg;
  logic                                    solvable_reg;
  logic                                    overflow_reg;
  logic [MAX_COLS_W-1:0]                   min_weight_reg;
`ifdef GF2_MIN_WEIGHT_SOLVER_SOLUTION_OUT_EN
  logic [MAX_COLS-1:0]                     best_x_reg;
  logic [MAX_COLS-1:0]                     solution_reg;
`endif

  // Column masks derived from the latched column count
  logic [MAX_COLS-1:0] var_mask;
  logic [MAX_COLS-1:0] rhs_mask;

  for (genvar gi = 0; gi < MAX_COLS; gi++) begin : g_col
    assign var_mask[gi] = (32'(gi) + 32'(cols_reg)) >  32'(MAX_COLS);
    assign rhs_mask[gi] = (32'(gi) + 32'(cols_reg)) == 32'(MAX_COLS);
  end

  // Row scan
  logic [MAX_COLS-1:0]       scan_row;
  logic [MAX_COLS-1:0]       scan_vars;
  logic                      scan_rhs;
  logic                      scan_has_pivot;
  logic [MAX_COLS_IDX_W-1:0] scan_pivot_idx;
  logic [MAX_COLS-1:0]       scan_pivot_bit;
  logic                      scan_last;
  logic [MAX_COLS-1:0]       scan_free_mask;
  logic [MAX_COLS_W-1:0]     scan_nfree;
  logic                      scan_ovf;
  logic                      scan_incons;

  assign scan_row       = mat_reg[row_idx_reg[ROW_IDX_W-1:0]];
  assign scan_vars      = scan_row & var_mask;
  assign scan_rhs       = |(scan_row & rhs_mask);
  assign scan_has_pivot = |scan_vars;
  assign scan_last      = (row_idx_reg == rows_reg - 1'b1);

  // Ascending sweep: the last hit is the highest set variable bit.
  always_comb begin
    scan_pivot_idx = '0;
    for (int b = 0; b < MAX_COLS; b++) begin
      if (scan_vars[b]) begin
        scan_pivot_idx = MAX_COLS_IDX_W'(b);
      end
    end
  end

  assign scan_pivot_bit = scan_has_pivot ? (MAX_COLS'(1) << scan_pivot_idx) : '0;
  assign scan_free_mask = var_mask & ~(pivot_mask_reg | scan_pivot_bit);
  assign scan_nfree     = MAX_COLS_W'(popcount(64'(scan_free_mask)));
  assign scan_ovf       = int'(scan_nfree) > MAX_FREE;
  assign scan_incons    = incons_reg | (!scan_has_pivot && scan_rhs);

  // Enumeration datapath
  logic [MAX_COLS-1:0]               free_assign;
  logic [MAX_ROWS-1:0][MAX_COLS-1:0] pivot_set;
  logic [MAX_COLS-1:0]               enum_x;
  logic [MAX_COLS_W-1:0]             enum_w;
  logic [MAX_FREE:0]                 cnt_inc;
  logic [MAX_FREE:0]                 cnt_end;
  logic                              enum_last;

  gf2_pdep #(
    .MAX_COLS (MAX_COLS),
    .MAX_FREE (MAX_FREE)
  ) u_pdep (
    .cnt  (cnt_reg),
    .mask (free_mask_reg),
    .dep  (free_assign)
  );

  for (genvar gi = 0; gi < MAX_ROWS; gi++) begin : g_row
    logic [MAX_COLS-1:0] row_vars;
    logic                row_rhs;
    logic                pivot_val;
    assign row_vars  = mat_reg[gi] & var_mask;
    assign row_rhs   = |(mat_reg[gi] & rhs_mask);
    assign pivot_val = row_rhs ^ (^(row_vars & free_assign));
    assign pivot_set[gi] = (pivot_valid_reg[gi] && pivot_val)
                         ? (MAX_COLS'(1) << pivot_col_reg[gi]) : '0;
  end

  always_comb begin
    enum_x = free_assign;
    for (int r = 0; r < MAX_ROWS; r++) begin
      enum_x = enum_x | pivot_set[r];
    end
  end

  assign enum_w    = MAX_COLS_W'(popcount(64'(enum_x)));
  assign cnt_inc   = {1'b0, cnt_reg} + 1'b1;
  assign cnt_end   = (MAX_FREE + 1)'(1) << nfree_reg;
  assign enum_last = (cnt_inc == cnt_end);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (bus.start) state_next = ST_SCAN;
      ST_SCAN: if (scan_last) state_next = (scan_incons || scan_ovf) ? ST_DONE : ST_ENUM;
      ST_ENUM: if (enum_last) state_next = ST_DONE;
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  logic solvable_next;
  assign solvable_next = !incons_reg && !free_ovf_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mat_reg         <= '0;
      rows_reg        <= '0;
      cols_reg        <= '0;
      row_idx_reg     <= '0;
      pivot_mask_reg  <= '0;
      pivot_col_reg   <= '0;
      pivot_valid_reg <= '0;
      incons_reg      <= 1'b0;
      free_ovf_reg    <= 1'b0;
      free_mask_reg   <= '0;
      nfree_reg       <= '0;
      cnt_reg         <= '0;
      best_w_reg      <= '0;
      ready_reg       <= 1'b0;
      solvable_reg    <= 1'b0;
      overflow_reg    <= 1'b0;
      min_weight_reg  <= '0;
`ifdef GF2_MIN_WEIGHT_SOLVER_SOLUTION_OUT_EN
      best_x_reg      <= '0;
      solution_reg    <= '0;
`endif
    end else begin
      ready_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (bus.start) begin
            mat_reg         <= bus.RREF;
            rows_reg        <= bus.rows;
            cols_reg        <= bus.cols;
            row_idx_reg     <= '0;
            pivot_mask_reg  <= '0;
            pivot_valid_reg <= '0;
            incons_reg      <= 1'b0;
            cnt_reg         <= '0;
          end
        end
        ST_SCAN: begin
          pivot_col_reg[row_idx_reg[ROW_IDX_W-1:0]]   <= scan_pivot_idx;
          pivot_valid_reg[row_idx_reg[ROW_IDX_W-1:0]] <= scan_has_pivot;
          pivot_mask_reg <= pivot_mask_reg | scan_pivot_bit;
          incons_reg     <= scan_incons;
          row_idx_reg    <= row_idx_reg + 1'b1;
          if (scan_last) begin
            free_mask_reg <= scan_free_mask;
            nfree_reg     <= scan_nfree;
            free_ovf_reg  <= scan_ovf;
          end
        end
        ST_ENUM: begin
          // Strict compare keeps the earliest counter value on ties.
          if (cnt_reg == '0 || enum_w < best_w_reg) begin
            best_w_reg <= enum_w;
`ifdef GF2_MIN_WEIGHT_SOLVER_SOLUTION_OUT_EN
            best_x_reg <= enum_x;
`endif
          end
          cnt_reg <= cnt_reg + 1'b1;
        end
        ST_DONE: begin
          solvable_reg   <= solvable_next;
          overflow_reg   <= free_ovf_reg;
          min_weight_reg <= solvable_next ? best_w_reg : '0;
`ifdef GF2_MIN_WEIGHT_SOLVER_SOLUTION_OUT_EN
          solution_reg   <= solvable_next ? best_x_reg : '0;
`endif
          ready_reg      <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.ready      = ready_reg;
  assign bus.solvable   = solvable_reg;
  assign bus.overflow   = overflow_reg;
  assign bus.min_weight = min_weight_reg;
  assign bus.busy       = (state_reg != ST_IDLE);
`ifdef GF2_MIN_WEIGHT_SOLVER_SOLUTION_OUT_EN
  assign bus.solution   = solution_reg;
`endif

endmodule

// File: doc/gf2_min_weight_solver.md
Name: gf2_min_weight_solver

Overview:
- Consumes the reduced row-echelon form [A|b] produced by the GF(2) RREF engine.
- Identifies pivot and free variables and detects inconsistency.
- Enumerates every free-variable assignment, one per cycle, and reports the minimum Hamming-weight solution of A·x = b.
- Sits directly downstream of the RREF engine: its RREF/ready outputs feed this block's RREF/start inputs.

Parameters:
- MAX_ROWS, 16, maximum matrix rows.
- MAX_COLS, 16, maximum columns including the RHS column.
- MAX_FREE, 8, maximum free variables enumerated; enumeration counter width.
- MAX_ROWS_W / MAX_COLS_W, derived, $clog2(N+1) with a floor of 1.
- MAX_COLS_IDX_W, derived, $clog2(MAX_COLS) with a floor of 1.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset
- rows  in  MAX_ROWS_W  active rows, 1..MAX_ROWS
- cols  in  MAX_COLS_W  active columns incl. RHS, 2..MAX_COLS
- start  in  1  one-cycle request; matrix sampled this cycle
- RREF  in  [MAX_COLS-1:0] x MAX_ROWS  reduced matrix
- ready  out  1  one-cycle done pulse
- solvable  out  1  system consistent and enumeration completed
- overflow  out  1  free-variable count > MAX_FREE
- min_weight  out  MAX_COLS_W  popcount of best solution
- busy  out  1  high outside IDLE

Behaviour:
- Clock clk; reset rst_n, synchronous, active-low.
- On reset: every register and output is 0, state is IDLE.
- Column layout:
  - Variable v occupies bit MAX_COLS-1-v, for v = 0..cols-2.
  - RHS is bit MAX_COLS-cols.
  - Bits below the RHS are ignored.
  - Rows at or above `rows` are ignored.
- States: IDLE, SCAN, ENUM, DONE.
- IDLE:
  - On start, latch RREF, rows and cols; clear pivot_mask, row index and counter; go to SCAN.
  - start is ignored in every other state.
- SCAN: one row per cycle, r = 0..rows-1.
  - Pivot of row r is the highest set variable bit. Store pivot_col[r] and pivot_valid[r], and set the pivot bit in pivot_mask.
  - If a row has no variable bit but its RHS bit is 1, set the inconsistent flag.
  - After the last row, compute nfree = popcount(var_mask & ~pivot_mask).
  - If inconsistent or nfree > MAX_FREE, go to DONE without enumerating. Otherwise go to ENUM.
- ENUM: one assignment per cycle; counter runs 0..2^nfree-1.
  - The k-th free variable in ascending v order takes counter bit k (bit deposit).
  - For each pivot row r, x[pivot_col[r]] = rhs[r] XOR parity(row_vars[r] & free_assign).
  - weight = popcount(x). Update best when the weight is strictly lower, or on counter 0. Ties therefore keep the lowest counter value.
  - Go to DONE after the last count. nfree = 0 takes exactly 1 ENUM cycle.
- DONE, 1 cycle:
  - Register outputs: solvable = !inconsistent && !overflow.
  - min_weight = best, or 0 if not solvable.
  - ready pulses on the following cycle; return to IDLE.
- Outputs hold until the next DONE.
- Latency from start to ready is 1 + rows + 2^nfree + 1 cycles. The inconsistent/overflow path skips the 2^nfree term.
- Reset mid-operation: return to IDLE immediately; no ready pulse; outputs cleared.

Optional Feature:
- Macro: GF2_MIN_WEIGHT_SOLVER_SOLUTION_OUT_EN.
- Defined:
  - Adds output port solution, [MAX_COLS-1:0], holding the argmin x in the variable bit positions with all other bits 0.
  - Registered with min_weight; 0 when not solvable.
- Undefined: the port and the best-vector register are absent; only the weight is produced.

Decomposition:
- Shared package gf2_pkg:
  - solver state enum;
  - width helper functions (clog2 with floor 1);
  - a popcount function.
  - The RREF engine can adopt the same helpers.
- One sub-module, gf2_pdep: combinational bit-deposit of the counter into free_mask positions, parameterised by MAX_COLS and MAX_FREE.

Test Plan (MAX_ROWS=4, MAX_COLS=8, MAX_FREE=2):
1. Free-variable case:
   - Stimulus: cols=4, rows=2, RREF={8'hB0, 8'h60}.
   - Required: 2 ENUM cycles, solvable=1, min_weight=1, solution=8'h80; ready exactly 1+2+2+1 cycles after start.
2. Inconsistent system:
   - Stimulus: cols=4, rows=2, RREF={8'hB0, 8'h10}.
   - Required: no ENUM, solvable=0, min_weight=0, overflow=0.
3. No free variables:
   - Stimulus: cols=4, rows=3, RREF={8'h90, 8'h50, 8'h20}.
   - Required: 1 ENUM cycle, min_weight=2, solution=8'hC0.
4. Free-count overflow:
   - Stimulus: cols=4, rows=1, RREF row0=8'h00.
   - Required: nfree=3 > 2, so overflow=1, solvable=0.
5. Weight tie:
   - Stimulus: cols=3, rows=1, RREF row0=8'hE0 (x0+x1=1).
   - Required: the two weight-1 solutions tie; the counter-0 assignment wins, so solution=8'h80.
6. Reset and start handling:
   - Assert rst_n=0 mid-ENUM: busy=0 and outputs 0 next cycle, no ready.
   - Pulse start while busy: ignored; exactly one ready per accepted start.
